// File: rtl/sequencia_pkg.sv
// Shared types and helpers for the multi-pattern serial detector.
// Optional build macro used by the top level: SEQUENCIA_NO_OVERLAP_EN.
package sequencia_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RECEBENDO  = 2'd1,
        ENCONTRADO = 2'd2
    } state_t;

    localparam logic MODE_STOP = 1'b0;
    localparam logic MODE_CONT = 1'b1;

    // Slot index width; a single slot still needs a 1-bit index port.
    function automatic int pat_idx_w(input int n_pat);
        if (n_pat <= 2) begin
            return 1;
        end else begin
            return $clog2(n_pat);
        end
    endfunction

endpackage

// File: rtl/sequencia_multi_if.sv
// Control/data bundle between the bit source, the control FSM and the detector.
interface sequencia_multi_if #(
    parameter int WIDTH = 8,
    parameter int N_PAT = 2,
    parameter int CNT_W = 8
);
    localparam int PAT_IDX_W = sequencia_pkg::pat_idx_w(N_PAT);

    logic                 setar_palavra;
    logic [PAT_IDX_W-1:0] sel_pat;
    logic [WIDTH-1:0]     palavra;
    logic [WIDTH-1:0]     mascara;
    logic                 start;
    logic                 parar;
    logic                 modo;
    logic                 bit_in;
    logic                 encontrado;
    logic [PAT_IDX_W-1:0] indice_match;
    logic [CNT_W-1:0]     contagem;
    logic                 ocupado;

    modport master (
        output setar_palavra, sel_pat, palavra, mascara, start, parar, modo, bit_in,
        input  encontrado, indice_match, contagem, ocupado
    );

    modport slave (
        input  setar_palavra, sel_pat, palavra, mascara, start, parar, modo, bit_in,
        output encontrado, indice_match, contagem, ocupado
    );

endinterface

// File: rtl/seq_match_slot.sv
// One pattern slot: stored pattern and compare mask plus the masked window compare.
module seq_match_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] palavra,
    input  logic [WIDTH-1:0] mascara,
    input  logic [WIDTH-1:0] data,
    output logic             hit
);
    logic [WIDTH-1:0] pat_r;
    logic [WIDTH-1:0] mask_r;

    // Pattern/mask storage, written only when this slot is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r  <= {WIDTH{1'b0}};
            mask_r <= {WIDTH{1'b0}};
        end else if (we) begin
            pat_r  <= palavra;
            mask_r <= mascara;
        end else begin
            pat_r  <= pat_r;
            mask_r <= mask_r;
        end
    end

    assign hit = (((data ^ pat_r) & mask_r) == {WIDTH{1'b0}});

endmodule

// File: rtl/sequencia_multi.sv
// Multi-pattern serial detector: FSM, shift window, priority encoder and hit counter.
// Build macro SEQUENCIA_NO_OVERLAP_EN makes continuous-mode hits non-overlapping.
module sequencia_multi
    import sequencia_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_PAT = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sequencia_multi_if.slave  bus
);
    localparam int PAT_IDX_W = pat_idx_w(N_PAT);
    localparam int FILL_W    = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

    state_t               state_r;
    // Only the newest WIDTH-1 bits are kept; the incoming bit completes the window.
    logic [WIDTH-2:0]     sr_r;
    logic [FILL_W-1:0]    fill_r;
    logic                 modo_r;
    logic                 encontrado_r;
    logic [PAT_IDX_W-1:0] indice_r;
    logic [CNT_W-1:0]     contagem_r;
    logic                 ocupado_r;

    logic [WIDTH-1:0]     nxt_s;
    logic [FILL_W-1:0]    fill_inc_s;
    logic [N_PAT-1:0]     hit_vec_s;
    logic [PAT_IDX_W-1:0] idx_s;
    logic                 match_s;
    logic [CNT_W-1:0]     cnt_inc_s;

    assign nxt_s      = {sr_r, bus.bit_in};
    assign fill_inc_s = (fill_r == FILL_FULL) ? FILL_FULL : fill_r + FILL_W'(1);
    assign match_s    = (|hit_vec_s) && (fill_inc_s == FILL_FULL);
    assign cnt_inc_s  = (&contagem_r) ? contagem_r : contagem_r + CNT_W'(1);

    for (genvar k = 0; k < N_PAT; k++) begin : g_slot
        seq_match_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (bus.setar_palavra && (bus.sel_pat == PAT_IDX_W'(k))),
            .palavra (bus.palavra),
            .mascara (bus.mascara),
            .data    (nxt_s),
            .hit     (hit_vec_s[k])
        );
    end

    // Priority encoder: scanning downward leaves the lowest matching slot.
    always_comb begin
        idx_s = {PAT_IDX_W{1'b0}};
        for (int k = N_PAT - 1; k >= 0; k--) begin
            idx_s = hit_vec_s[k] ? PAT_IDX_W'(k) : idx_s;
        end
    end

    // Control FSM with registered outputs; setar/parar outrank start, which outranks shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            sr_r         <= {(WIDTH-1){1'b0}};
            fill_r       <= {FILL_W{1'b0}};
            modo_r       <= MODE_STOP;
            encontrado_r <= 1'b0;
            indice_r     <= {PAT_IDX_W{1'b0}};
            contagem_r   <= {CNT_W{1'b0}};
            ocupado_r    <= 1'b0;
        end else if (bus.setar_palavra || bus.parar) begin
            state_r      <= IDLE;
            sr_r         <= {(WIDTH-1){1'b0}};
            fill_r       <= {FILL_W{1'b0}};
            encontrado_r <= 1'b0;
            indice_r     <= {PAT_IDX_W{1'b0}};
            ocupado_r    <= 1'b0;
        end else if (bus.start) begin
            state_r      <= RECEBENDO;
            sr_r         <= (WIDTH-1)'(bus.bit_in);
            fill_r       <= FILL_W'(1);
            modo_r       <= bus.modo;
            encontrado_r <= 1'b0;
            indice_r     <= {PAT_IDX_W{1'b0}};
            contagem_r   <= {CNT_W{1'b0}};
            ocupado_r    <= 1'b1;
        end else begin
            case (state_r)
                RECEBENDO: begin
                    sr_r <= nxt_s[WIDTH-2:0];
                    if (match_s) begin
                        encontrado_r <= 1'b1;
                        indice_r     <= idx_s;
                        contagem_r   <= cnt_inc_s;
                        if (modo_r == MODE_STOP) begin
                            state_r   <= ENCONTRADO;
                            ocupado_r <= 1'b0;
                            fill_r    <= fill_inc_s;
                        end else begin
                            state_r   <= RECEBENDO;
                            ocupado_r <= 1'b1;
`ifdef SEQUENCIA_NO_OVERLAP_EN
                            fill_r    <= {FILL_W{1'b0}};
`else
                            fill_r    <= fill_inc_s;
`endif
                        end
                    end else begin
                        encontrado_r <= 1'b0;
                        indice_r     <= {PAT_IDX_W{1'b0}};
                        fill_r       <= fill_inc_s;
                    end
                end
                IDLE: begin
                    state_r <= IDLE;
                end
                ENCONTRADO: begin
                    state_r <= ENCONTRADO;
                end
                default: begin
                    state_r      <= IDLE;
                    encontrado_r <= 1'b0;
                    ocupado_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.encontrado   = encontrado_r;
    assign bus.indice_match = indice_r;
    assign bus.contagem     = contagem_r;
    assign bus.ocupado      = ocupado_r;

endmodule

// File: tb/tb_sequencia_multi.sv
// Scoreboard bench for sequencia_multi with WIDTH=8, N_PAT=2, CNT_W=8.
module tb_sequencia_multi;
    import sequencia_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sequencia_multi_if #(.WIDTH(8), .N_PAT(2), .CNT_W(8)) bus ();

    sequencia_multi #(.WIDTH(8), .N_PAT(2), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       enc;
        logic       idx;
        logic [7:0] cnt;
        logic       ocup;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic enc, input logic idx, input int cnt, input logic ocup);
        exp_t e;
        e.enc  = enc;
        e.idx  = idx;
        e.cnt  = 8'(cnt);
        e.ocup = ocup;
        sb_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check_val({tag, ".encontrado"}, 32'(bus.encontrado), 32'(e.enc));
        if (e.enc) check_val({tag, ".indice"}, 32'(bus.indice_match), 32'(e.idx));
        check_val({tag, ".contagem"}, 32'(bus.contagem), 32'(e.cnt));
        check_val({tag, ".ocupado"}, 32'(bus.ocupado), 32'(e.ocup));
    endtask

    // One clock with bit b on the line, then compare against the expectation queued for it.
    task automatic step(input logic b, input logic enc, input logic idx, input int cnt,
                        input logic ocup, input string tag);
        push_exp(enc, idx, cnt, ocup);
        bus.bit_in = b;
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic write_slot(input int k, input logic [7:0] p, input logic [7:0] m, input int cnt);
        bus.setar_palavra = 1'b1;
        bus.sel_pat       = 1'(k);
        bus.palavra       = p;
        bus.mascara       = m;
        step(1'b0, 1'b0, 1'b0, cnt, 1'b0, "setar");
        bus.setar_palavra = 1'b0;
    endtask

    task automatic run_mode0(input logic [7:0] s, input logic exp_idx, input string tag);
        bus.start = 1'b1;
        bus.modo  = MODE_STOP;
        step(s[7], 1'b0, 1'b0, 0, 1'b1, {tag, "_b1"});
        bus.start = 1'b0;
        for (int i = 6; i >= 1; i--) step(s[i], 1'b0, 1'b0, 0, 1'b1, {tag, "_fill"});
        step(s[0], 1'b1, exp_idx, 1, 1'b0, {tag, "_hit"});
    endtask

    logic [9:0] s10;
    int         cnt_exp;
    logic       enc_exp;

    initial begin
        rst_n = 1'b0;
        bus.setar_palavra = 1'b0; bus.sel_pat = 1'b0; bus.palavra = 8'h00; bus.mascara = 8'h00;
        bus.start = 1'b0; bus.parar = 1'b0; bus.modo = 1'b0; bus.bit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_exp(1'b0, 1'b0, 0, 1'b0);
        compare_out("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Exact match, then held outputs while bits keep arriving.
        write_slot(0, 8'hA5, 8'hFF, 0);
        write_slot(1, 8'hFF, 8'hFF, 0);
        run_mode0(8'hA5, 1'b0, "exact");
        for (int i = 0; i < 3; i++) step(1'($urandom_range(1)), 1'b1, 1'b0, 1, 1'b0, "hold");

        // All-zero pattern: no hit until the window has filled.
        write_slot(0, 8'h00, 8'hFF, 1);
        write_slot(1, 8'hFF, 8'hFF, 1);
        run_mode0(8'h00, 1'b0, "zeros");

        // Two slots match together: lowest index wins; then only slot 1 matches.
        write_slot(0, 8'hA0, 8'hF0, 1);
        write_slot(1, 8'hAF, 8'hFF, 1);
        run_mode0(8'hAF, 1'b0, "both");
        write_slot(1, 8'h5F, 8'hFF, 1);
        run_mode0(8'h5F, 1'b1, "slot1");

        // Continuous mode on 1010101010 against AA.
        write_slot(0, 8'hAA, 8'hFF, 1);
        write_slot(1, 8'hFF, 8'hFF, 1);
        s10 = 10'b1010101010;
        bus.start = 1'b1;
        bus.modo  = MODE_CONT;
        step(s10[9], 1'b0, 1'b0, 0, 1'b1, "cont_b1");
        bus.start = 1'b0;
        for (int j = 2; j <= 10; j++) begin
`ifdef SEQUENCIA_NO_OVERLAP_EN
            enc_exp = (j == 8);
            cnt_exp = (j >= 8) ? 1 : 0;
`else
            enc_exp = (j == 8) || (j == 10);
            cnt_exp = (j >= 10) ? 2 : ((j >= 8) ? 1 : 0);
`endif
            step(s10[10-j], enc_exp, 1'b0, cnt_exp, 1'b1, "cont");
        end
        bus.parar = 1'b1;
        step(1'b0, 1'b0, 1'b0, cnt_exp, 1'b0, "parar");
        bus.parar = 1'b0;

        // Don't-care slot in continuous mode: counter must saturate.
        write_slot(0, 8'h00, 8'h00, cnt_exp);
        bus.start = 1'b1;
        bus.modo  = MODE_CONT;
        step(1'($urandom_range(1)), 1'b0, 1'b0, 0, 1'b1, "sat_b1");
        bus.start = 1'b0;
        for (int j = 2; j <= 300; j++) begin
`ifdef SEQUENCIA_NO_OVERLAP_EN
            enc_exp = ((j % 8) == 0);
            cnt_exp = j / 8;
`else
            enc_exp = (j >= 8);
            cnt_exp = (j < 8) ? 0 : (((j - 7) > 255) ? 255 : (j - 7));
`endif
            step(1'($urandom_range(1)), enc_exp, 1'b0, cnt_exp, 1'b1, "sat");
        end

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, 1'b0, 0, 1'b0);
        compare_out("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // setar and start together: write wins, detector stays idle.
        bus.setar_palavra = 1'b1;
        bus.sel_pat       = 1'b0;
        bus.palavra       = 8'hA5;
        bus.mascara       = 8'hFF;
        bus.start         = 1'b1;
        bus.modo          = MODE_STOP;
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, "setar_start");
        bus.setar_palavra = 1'b0;
        bus.start         = 1'b0;
        run_mode0(8'hA5, 1'b0, "stored");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
